// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: per-source edge/level latching and masking,
// fixed lowest-index-wins priority, and a request/ack/EOI handshake toward CP0.
module irq_ctrl #(
    parameter int NSRC = 6
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [1:0]      Addr,
    input  logic [31:0]     Wd,
    input  logic            We,
    output logic [31:0]     Rd,
    input  logic [NSRC-1:0] IrqIn,
    input  logic            IntAck,
    output logic            IntReq,
    output logic [NSRC-1:0] HWInt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_REQ     = 2'b01,
        S_SERVICE = 2'b10,
        S_UNUSED  = 2'b11
    } state_t;

    state_t            state_reg, state_next;
    logic [2:0]        id_reg, id_next;
    logic [NSRC-1:0]   mask_reg, mode_reg, pend_reg, prev_reg, hwint_reg;
    logic [NSRC-1:0]   pend_next, rise, clr, act;
    logic [2:0]        enc;
    logic              valid, act_id;
    logic              wr_mask, wr_pend, wr_mode, eoi;
    logic              wd_unused;

    // Upper write-data bits have no register behind them.
    assign wd_unused = ^Wd[31:NSRC];

    assign wr_mask = We && (Addr == 2'd0);
    assign wr_pend = We && (Addr == 2'd1);
    assign wr_mode = We && (Addr == 2'd2);
    assign eoi     = We && (Addr == 2'd3) && (state_reg == S_SERVICE);

    assign act   = pend_reg & mask_reg;
    assign valid = |act;

    always_comb begin
        enc = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (act[i]) enc = 3'(i);
        end
    end

    always_comb begin
        act_id = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (id_reg == 3'(i)) act_id = act[i];
        end
    end

    // A rising edge beats any clear in the same cycle.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
            assign rise[gi]      = IrqIn[gi] & ~prev_reg[gi];
            assign clr[gi]       = (wr_pend & Wd[gi]) | (eoi & (id_reg == 3'(gi)));
            assign pend_next[gi] = mode_reg[gi] ? (rise[gi] | (pend_reg[gi] & ~clr[gi]))
                                                : IrqIn[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        case (state_reg)
            S_IDLE: begin
                if (valid) begin
                    state_next = S_REQ;
                    id_next    = enc;
                end
            end
            S_REQ: begin
                // Keep tracking the encoder so a higher-priority arrival preempts.
                if (valid) id_next = enc;
                if (IntAck)       state_next = S_SERVICE;
                else if (!act_id) state_next = S_IDLE;
            end
            S_SERVICE: begin
                if (eoi) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mask_reg  <= '0;
            mode_reg  <= '0;
            pend_reg  <= '0;
            prev_reg  <= '0;
            hwint_reg <= '0;
            state_reg <= S_IDLE;
            id_reg    <= '0;
        end else begin
            if (wr_mask) mask_reg <= Wd[NSRC-1:0];
            if (wr_mode) mode_reg <= Wd[NSRC-1:0];
            pend_reg  <= pend_next;
            prev_reg  <= IrqIn;
            hwint_reg <= act;
            state_reg <= state_next;
            id_reg    <= id_next;
        end
    end

    assign IntReq = (state_reg == S_REQ);
    assign HWInt  = hwint_reg;

    always_comb begin
        Rd = '0;
        case (Addr)
            2'd0:    Rd[NSRC-1:0] = mask_reg;
            2'd1:    Rd[NSRC-1:0] = pend_reg;
            2'd2:    Rd[NSRC-1:0] = mode_reg;
            default: Rd[5:0]      = {state_reg, valid, id_reg};
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed handshake scenarios followed by random traffic,
// all compared against a per-cycle behavioural model of the controller.
module tb_irq_ctrl;
    localparam int N = 6;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [1:0]    Addr = '0;
    logic [31:0]   Wd = '0;
    logic          We = 1'b0;
    logic [31:0]   Rd;
    logic [N-1:0]  IrqIn = '0;
    logic          IntAck = 1'b0;
    logic          IntReq;
    logic [N-1:0]  HWInt;

    int tests = 0;
    int fails = 0;

    irq_ctrl #(.NSRC(N)) dut (
        .Clk(Clk), .Reset(Reset), .Addr(Addr), .Wd(Wd), .We(We), .Rd(Rd),
        .IrqIn(IrqIn), .IntAck(IntAck), .IntReq(IntReq), .HWInt(HWInt)
    );

    always #5 Clk = ~Clk;

    // Reference model: 0 = idle, 1 = requesting, 2 = in service.
    bit m_mask[N], m_mode[N], m_pend[N], m_prev[N], m_hw[N];
    int m_state = 0;
    int m_id = 0;

    function automatic int winner();
        for (int i = 0; i < N; i++) if (m_pend[i] && m_mask[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: for (int i = 0; i < N; i++) r[i] = m_mask[i];
            2'd1: for (int i = 0; i < N; i++) r[i] = m_pend[i];
            2'd2: for (int i = 0; i < N; i++) r[i] = m_mode[i];
            default: r = 32'(m_state * 16 + ((winner() >= 0) ? 8 : 0) + m_id);
        endcase
        return r;
    endfunction

    function automatic logic [31:0] model_hw();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i] = m_hw[i];
        return r;
    endfunction

    task automatic model_tick();
        bit n_pend[N];
        int win, n_state, n_id;
        bit eoi;
        if (Reset) begin
            for (int i = 0; i < N; i++) begin
                m_mask[i] = 0; m_mode[i] = 0; m_pend[i] = 0; m_prev[i] = 0; m_hw[i] = 0;
            end
            m_state = 0;
            m_id = 0;
            return;
        end
        win = winner();
        eoi = We && (Addr == 2'd3) && (m_state == 2);
        for (int i = 0; i < N; i++) begin
            if (!m_mode[i]) n_pend[i] = IrqIn[i];
            else if (IrqIn[i] && !m_prev[i]) n_pend[i] = 1;
            else if ((We && Addr == 2'd1 && Wd[i]) || (eoi && m_id == i)) n_pend[i] = 0;
            else n_pend[i] = m_pend[i];
        end
        n_state = m_state;
        if (m_state == 0 && win >= 0) n_state = 1;
        else if (m_state == 1 && IntAck) n_state = 2;
        else if (m_state == 1 && !(m_pend[m_id] && m_mask[m_id])) n_state = 0;
        else if (m_state == 2 && eoi) n_state = 0;
        n_id = (m_state != 2 && win >= 0) ? win : m_id;
        for (int i = 0; i < N; i++) begin
            m_hw[i]   = m_pend[i] && m_mask[i];
            m_pend[i] = n_pend[i];
            m_prev[i] = IrqIn[i];
            if (We && Addr == 2'd0) m_mask[i] = Wd[i];
            if (We && Addr == 2'd2) m_mode[i] = Wd[i];
        end
        m_state = n_state;
        m_id = n_id;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        model_tick();
        @(posedge Clk);
        #1;
        chk("intreq", {31'b0, IntReq}, (m_state == 1) ? 32'd1 : 32'd0);
        chk("hwint", {26'b0, HWInt}, model_hw());
        chk("rd", Rd, model_read(Addr));
    endtask

    task automatic peek(input logic [1:0] a, input logic [31:0] exp, input string tag);
        Addr = a;
        #1;
        chk(tag, Rd, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        We = 1'b1; Addr = a; Wd = d;
        step();
        We = 1'b0; Wd = '0;
    endtask

    task automatic ack();
        IntAck = 1'b1;
        step();
        IntAck = 1'b0;
    endtask

    initial begin
        // Reset
        Reset = 1'b1; step(); step(); Reset = 1'b0;
        peek(2'd3, 32'h0, "status_after_reset");
        chk("intreq_after_reset", {31'b0, IntReq}, 32'd0);

        // Edge source 0: pulse, request, ack, EOI
        wr(2'd2, 32'h1); wr(2'd0, 32'h1);
        IrqIn = 6'h01; step(); IrqIn = '0;
        peek(2'd1, 32'h1, "t1_pending_set");
        chk("t1_no_req_yet", {31'b0, IntReq}, 32'd0);
        step();
        chk("t1_req", {31'b0, IntReq}, 32'd1);
        peek(2'd3, 32'h18, "t1_status_req");
        ack();
        peek(2'd3, 32'h28, "t1_status_service");
        wr(2'd3, 32'h0);
        peek(2'd1, 32'h0, "t1_pending_cleared");
        peek(2'd3, 32'h0, "t1_status_idle");
        step();
        chk("t1_no_rerequest", {31'b0, IntReq}, 32'd0);

        // Level source 2: re-request after EOI, then drop before ack
        wr(2'd2, 32'h0); wr(2'd0, 32'h4);
        IrqIn = 6'h04; step(); step();
        chk("t2_req", {31'b0, IntReq}, 32'd1);
        peek(2'd3, 32'h1A, "t2_status_req");
        ack();
        wr(2'd3, 32'h0);
        chk("t2_idle_after_eoi", {31'b0, IntReq}, 32'd0);
        step();
        chk("t2_rerequest", {31'b0, IntReq}, 32'd1);
        IrqIn = '0; step(); step();
        chk("t2_drop_no_ack", {31'b0, IntReq}, 32'd0);

        // Two edge sources pending: 0 served before 3
        wr(2'd2, 32'h3F); wr(2'd0, 32'h3F);
        IrqIn = 6'h09; step(); IrqIn = '0; step();
        peek(2'd3, 32'h18, "t3_first_id0");
        ack(); wr(2'd3, 32'h0); step();
        peek(2'd3, 32'h1B, "t3_then_id3");
        ack(); wr(2'd3, 32'h0);

        // Preemption in REQ: src4 then src1
        IrqIn = 6'h10; step(); IrqIn = '0; step();
        peek(2'd3, 32'h1C, "t4_req_id4");
        IrqIn = 6'h02; step(); IrqIn = '0; step();
        peek(2'd3, 32'h19, "t4_preempt_id1");
        ack();
        peek(2'd3, 32'h29, "t4_service_id1");
        wr(2'd3, 32'h0); step(); ack(); wr(2'd3, 32'h0);

        // Set beats W1C clear; masked source never requests
        wr(2'd0, 32'h0);
        IrqIn = 6'h01; wr(2'd1, 32'h1); IrqIn = '0;
        peek(2'd1, 32'h1, "t5_set_wins");
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_masked_noreq", {31'b0, IntReq}, 32'd0);
            chk("t5_masked_hwint", {26'b0, HWInt}, 32'd0);
        end

        // Reset from SERVICE
        wr(2'd0, 32'h1); step(); ack();
        peek(2'd3, 32'h28, "t6_in_service");
        Reset = 1'b1; step(); Reset = 1'b0;
        peek(2'd0, 32'h0, "t6_mask_zero");
        peek(2'd1, 32'h0, "t6_pend_zero");
        peek(2'd2, 32'h0, "t6_mode_zero");
        peek(2'd3, 32'h0, "t6_status_zero");
        chk("t6_intreq_zero", {31'b0, IntReq}, 32'd0);
        chk("t6_hwint_zero", {26'b0, HWInt}, 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            Reset  = ($urandom_range(0, 299) == 0);
            We     = ($urandom_range(0, 3) == 0);
            Addr   = 2'($urandom);
            Wd     = $urandom;
            IntAck = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) IrqIn[i] = ~IrqIn[i];
            step();
        end
        Reset = 1'b0; We = 1'b0; IntAck = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
